// File: rtl/keyboard_uart_decoder.sv
// keyboard_uart_decoder: 8N1 UART receiver plus single-key command decoder.
// Produces a saturating (x, y) target, a keyboard-mode flag and the last byte.
module keyboard_uart_decoder #(
    parameter int         CLKS_PER_BIT = 10417,
    parameter logic [7:0] X_MIN        = 8'd0,
    parameter logic [7:0] X_MAX        = 8'd15,
    parameter logic [7:0] Y_MIN        = 8'd0,
    parameter logic [7:0] Y_MAX        = 8'd15,
    parameter logic [7:0] HOME_X       = 8'd2,
    parameter logic [7:0] HOME_Y       = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       keyboard_controlled,
    output logic [7:0] keyboard_x,
    output logic [7:0] keyboard_y,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxs;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             w_cnt_last;
    logic             w_cnt_mid;
    logic             w_accept;
    logic             w_ferr;

    logic             r_mode;
    logic [7:0]       r_x;
    logic [7:0]       r_y;
    logic [7:0]       r_data;
    logic             r_byte_valid;
    logic             r_frame_error;

    assign w_rxs      = r_sync2;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_cnt_mid  = (r_cnt == CNT_MID);

    // Two-flop synchronizer for the asynchronous rx line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Receiver next-state logic and accept / framing-error strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_next_state = S_START;
            end
            S_START: begin
                if (w_cnt_mid) begin
                    w_next_state = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_last && (r_idx == 3'd7)) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    if (w_rxs) begin
                        w_accept     = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_next_state = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_rxs) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Bit timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            if (r_state == S_IDLE || r_state == S_WAIT_IDLE ||
                w_next_state != r_state || w_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_START) begin
                r_idx <= 3'd0;
            end else if (r_state == S_DATA && w_cnt_last) begin
                r_shift <= {w_rxs, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
            end
        end
    end

    // Command decoder: all outputs registered, movement saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode        <= 1'b0;
            r_x           <= HOME_X;
            r_y           <= HOME_Y;
            r_data        <= 8'd0;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_byte_valid  <= w_accept;
            r_frame_error <= w_ferr;
            if (w_accept) begin
                r_data <= r_shift;
                case (r_shift)
                    8'h6B: r_mode <= 1'b1;
                    8'h71: r_mode <= 1'b0;
                    8'h72: begin
                        r_x <= HOME_X;
                        r_y <= HOME_Y;
                    end
                    8'h64: if (r_mode && r_x < X_MAX) r_x <= r_x + 8'd1;
                    8'h61: if (r_mode && r_x > X_MIN) r_x <= r_x - 8'd1;
                    8'h77: if (r_mode && r_y < Y_MAX) r_y <= r_y + 8'd1;
                    8'h73: if (r_mode && r_y > Y_MIN) r_y <= r_y - 8'd1;
                    default: ;
                endcase
            end
        end
    end

    assign keyboard_controlled = r_mode;
    assign keyboard_x          = r_x;
    assign keyboard_y          = r_y;
    assign data                = r_data;
    assign byte_valid          = r_byte_valid;
    assign frame_error         = r_frame_error;

endmodule

// File: doc/keyboard_uart_decoder.md
Name: keyboard_uart_decoder

Overview:
- Upstream feeder of the arm FSM controller's keyboard path.
- Receives 8N1 UART bytes from the laptop on `rx` and decodes single-key ASCII commands into a clamped (x, y) target, a mode flag, and the last received byte.
- Outputs drive the controller's `keyboardControlled`, `keyboard_x`, `keyboard_y` and `data` inputs.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); must be >= 4.
- X_MIN, 0, lowest legal x.
- X_MAX, 15, highest legal x.
- Y_MIN, 0, lowest legal y.
- Y_MAX, 15, highest legal y.
- HOME_X, 2, x after reset or the 'r' command.
- HOME_Y, 2, y after reset or the 'r' command.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART line, idle high.
- keyboard_controlled  out  1  keyboard mode active.
- keyboard_x  out  8  target x, always in [X_MIN, X_MAX].
- keyboard_y  out  8  target y, always in [Y_MIN, Y_MAX].
- data  out  8  last correctly framed byte received.
- byte_valid  out  1  one-cycle pulse per correctly framed byte.
- frame_error  out  1  one-cycle pulse when a stop bit is sampled low.

Behaviour:
- Reset values:
  - keyboard_controlled=0, keyboard_x=HOME_X, keyboard_y=HOME_Y, data=0x00, byte_valid=0, frame_error=0.
  - Receiver goes to IDLE; both synchronizer flops are set to 1.
- Synchronizer: `rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Bit counter runs 0..CLKS_PER_BIT-1; bit index runs 0..7.
  - IDLE: rxs=0 -> START, counter cleared.
  - START: at counter = CLKS_PER_BIT/2 - 1 (start-bit mid-point), rxs=0 -> DATA with counter cleared; rxs=1 -> IDLE (glitch, no pulse).
  - DATA: sample rxs when counter = CLKS_PER_BIT-1, shifting LSB first. After the 8th sample -> STOP.
  - STOP: sample at counter = CLKS_PER_BIT-1.
    - rxs=1: byte accepted; byte_valid pulses on the next edge; -> IDLE.
    - rxs=0: frame_error pulses on the next edge; byte discarded; -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then -> IDLE (no restart on a held-low line/break).
- Decoder: acts on the same edge byte_valid is asserted; all outputs are registered.
  - data <= byte on every accepted byte, including unknown codes.
  - 0x6B 'k': keyboard_controlled <= 1.
  - 0x71 'q': keyboard_controlled <= 0; x and y unchanged.
  - 0x72 'r': x <= HOME_X, y <= HOME_Y; mode unchanged; applies in either mode.
  - 0x64 'd': x+1. 0x61 'a': x-1. 0x77 'w': y+1. 0x73 's': y-1.
  - Movement commands apply only when keyboard_controlled=1; otherwise ignored.
  - Any other code, including uppercase: position and mode unchanged.
- Arithmetic: saturating. x+1 at X_MAX stays at X_MAX; x-1 at X_MIN stays at X_MIN. Same for y. No 8-bit wrap is ever visible.
- Latency:
  - byte_valid, data, x, y and mode all update on the edge one cycle after the stop-bit sample edge.
  - Total latency from the start-bit falling edge at `rx` is about 9.5 bit times plus 3 cycles (2 synchronizer + 1 register).
- Simultaneous events:
  - byte_valid and frame_error never assert together.
  - A new start bit arriving one cycle after STOP is accepted, since IDLE is entered immediately.
- Reset mid-frame: partial byte discarded, no pulse, outputs return to reset values on that edge.

Test Plan (CLKS_PER_BIT=16):
- Reset, then send 'k' (0x6B) -> byte_valid pulses once, data=0x6B, keyboard_controlled=1, x=2, y=2.
- Mode on: send 'd' x3, 'w' x1 -> x=5, y=3. Then send 'q' and 'd' -> mode 0, x remains 5, data=0x64.
- Mode on: send 'a' x5 from x=2, then 'd' x20 -> x saturates at 0, then at 15, never 255 or 16. Same check for y using 's'/'w'.
- Frame error: send 0x64 with stop bit low, hold `rx` low 40 cycles, then high -> frame_error pulses once, no byte_valid, x and data unchanged. Then send 'r' -> x=2, y=2, data=0x72.
- Glitch: `rx` low for 4 cycles then high -> no byte_valid, no frame_error, FSM back in IDLE.
- Reset asserted during the 4th data bit of 'k' -> all outputs return to reset values. A following complete 'w' with mode 0 -> data=0x77, y=2.
